// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM (Moore): sequences fetch/decode/execute/memory/
// writeback over a shared memory and ALU, stalls on mem_ready, and traps
// illegal opcodes and memory timeouts into a sticky FAULT state.
// Optional feature macro: JUMP_EN (adds the J instruction via a JUMP state).
module mips_multicycle_controller #(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       regdst,
  output logic       mem2reg,
  output logic       regwrite,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
    S_MEM_WRITE, S_R_EXEC, S_R_WB, S_BRANCH, S_JUMP, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);
  localparam bit TIMEOUT_EN = (WAIT_LIMIT != 0);

  state_t            state_reg, state_next;
  logic [5:0]        opcode_reg;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]        fault_code_reg, fault_code_next;
  logic              waiting;
  logic              timeout;

  // A memory state is stalling when its handshake has not completed this cycle
  always_comb begin
    waiting = ((state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
               (state_reg == S_MEM_WRITE)) && !mem_ready;
    timeout = TIMEOUT_EN && waiting && (wait_cnt_reg == WAIT_MAX);
  end

  // Next-state and fault-code selection; a completed handshake beats the timeout
  always_comb begin
    state_next      = state_reg;
    fault_code_next = fault_code_reg;
    case (state_reg)
      S_IDLE:    state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
        else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef JUMP_EN
          OP_J:         state_next = S_JUMP;
`endif
          default: begin
            state_next      = S_FAULT;
            fault_code_next = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (opcode_reg == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) state_next = (state_reg == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (timeout) begin
          state_next      = S_FAULT;
          fault_code_next = 2'b10;
        end
      end
      S_MEM_WB, S_R_WB, S_BRANCH: state_next = S_FETCH;
      S_R_EXEC:  state_next = S_R_WB;
`ifdef JUMP_EN
      S_JUMP:    state_next = S_FETCH;
`endif
      S_FAULT:   state_next = S_FAULT;
      default:   state_next = S_IDLE;
    endcase
  end

  // Wait counter only advances while parked in a stalled memory state
  always_comb begin
    wait_cnt_next = '0;
    if ((state_next == state_reg) && waiting) wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
  end

  // State, captured opcode, wait counter and fault code registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      opcode_reg     <= '0;
      wait_cnt_reg   <= '0;
      fault_code_reg <= 2'b00;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      fault_code_reg <= fault_code_next;
      if (state_reg == S_DECODE) opcode_reg <= opcode;
    end
  end

  // Moore output decode; only handshake-qualified strobes look at mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    regdst        = 1'b0;
    mem2reg       = 1'b0;
    regwrite      = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = 2'b00;
    aluop         = 2'b00;
    pcsrc         = 2'b00;
    retire        = 1'b0;
    fault         = 1'b0;
    fault_code    = fault_code_reg;
    case (state_reg)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrc_b = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE:   alusrc_b = 2'b11;
      S_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        regwrite = 1'b1;
        mem2reg  = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_R_EXEC: begin
        alusrc_a = 1'b1;
        aluop    = 2'b10;
      end
      S_R_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrc_a      = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pcsrc         = 2'b01;
        retire        = 1'b1;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        pc_write = 1'b1;
        pcsrc    = 2'b10;
        retire   = 1'b1;
      end
`endif
      S_FAULT:  fault = 1'b1;
      default:  fault = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench for mips_multicycle_controller: the driver walks
// instruction-level sequences and queues the expected control word for every
// cycle; a negedge monitor pops and compares against the DUT outputs.
module tb_mips_multicycle_controller;

  localparam int LIM = 4;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

  typedef logic [19:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic regdst, mem2reg, regwrite, alusrc_a, retire, fault;
  logic [1:0] alusrc_b, aluop, pcsrc, fault_code;

  int tests = 0;
  int failed = 0;
  int instr_no = 0;
  vec_t exp_q[$];
  string name_q[$];
  vec_t act, exp_v;
  string exp_n;

  mips_multicycle_controller #(.WAIT_LIMIT(LIM), .WAIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .regdst(regdst), .mem2reg(mem2reg), .regwrite(regwrite),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .pcsrc(pcsrc),
    .retire(retire), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                regdst, mem2reg, regwrite, alusrc_a, alusrc_b, aluop, pcsrc,
                retire, fault, fault_code};

  // Control word builder: named fields in port order
  function automatic vec_t mk(bit pcw, bit pcwc, bit io, bit mrd, bit mwr, bit irw,
                              bit rdst, bit m2r, bit rw, bit asa, logic [1:0] asb,
                              logic [1:0] aop, logic [1:0] psrc, bit ret, bit flt,
                              logic [1:0] fc);
    return {pcw, pcwc, io, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, ret, flt, fc};
  endfunction

  // Expected control word of each step of an instruction
  function automatic vec_t step_vec(string nm, bit rdy, logic [1:0] fc);
    case (nm)
      "fetch":     return mk(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00,0,0,2'b00);
      "decode":    return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,2'b00);
      "mem_addr":  return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,2'b00);
      "mem_read":  return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,2'b00);
      "mem_wb":    return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0,2'b00);
      "mem_write": return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,rdy,0,2'b00);
      "r_exec":    return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,2'b00);
      "r_wb":      return mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0,2'b00);
      "branch":    return mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,2'b00);
      "jump":      return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,2'b00);
      "fault":     return mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,fc);
      default:     return '0;
    endcase
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue the word the DUT must show in it
  task automatic emit(input logic [5:0] op, input logic rdy, input string nm,
                      input logic [1:0] fc = 2'b00);
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(step_vec(nm, rdy, fc));
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  // Reset for one edge, then expect an all-zero IDLE cycle
  task automatic do_reset();
    rst_n     = 1'b0;
    opcode    = rnd_op();
    mem_ready = rnd_bit();
    @(posedge clk); #1;
    rst_n = 1'b1;
    emit(rnd_op(), rnd_bit(), "idle");
  endtask

  // Memory handshake step: 'stalls' not-ready cycles, timeout on the (LIM+1)th
  task automatic mem_step(input string nm, input int stalls, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      emit(rnd_op(), 1'b0, nm);
      if (i == LIM) begin
        timed_out = 1'b1;
        return;
      end
    end
    emit(rnd_op(), 1'b1, nm);
  endtask

  // Sticky fault: outputs stay quiet whatever the inputs, until reset
  task automatic fault_hold(input logic [1:0] fc);
    for (int i = 0; i < 3; i++) emit(rnd_op(), rnd_bit(), "fault", fc);
    do_reset();
  endtask

  // One complete instruction starting from FETCH
  task automatic issue(input logic [5:0] op, input int fs, input int ms);
    bit to;
    string what;
    instr_no++;
    what = "retired";
    mem_step("fetch", fs, to);
    if (to) begin
      fault_hold(2'b10);
      $display("[TB] instr %0d op=%b fetch_stall=%0d -> fetch timeout", instr_no, op, fs);
      return;
    end
    emit(op, rnd_bit(), "decode");
    if (op == OP_R) begin
      emit(rnd_op(), rnd_bit(), "r_exec");
      emit(rnd_op(), rnd_bit(), "r_wb");
    end else if (op == OP_LW || op == OP_SW) begin
      emit(rnd_op(), rnd_bit(), "mem_addr");
      mem_step(op == OP_LW ? "mem_read" : "mem_write", ms, to);
      if (to) begin
        fault_hold(2'b10);
        what = "memory timeout";
      end else if (op == OP_LW) begin
        emit(rnd_op(), rnd_bit(), "mem_wb");
      end
    end else if (op == OP_BEQ) begin
      emit(rnd_op(), rnd_bit(), "branch");
`ifdef JUMP_EN
    end else if (op == OP_J) begin
      emit(rnd_op(), rnd_bit(), "jump");
`endif
    end else begin
      fault_hold(2'b01);
      what = "illegal opcode";
    end
    $display("[TB] instr %0d op=%b fetch_stall=%0d mem_stall=%0d -> %s",
             instr_no, op, fs, ms, what);
  endtask

  // Monitor: compare every queued word against the DUT away from the edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      exp_n = name_q.pop_front();
      tests++;
      if (act !== exp_v) begin
        failed++;
        $display("FAIL %s: got %05h required %05h", exp_n, act, exp_v);
      end
    end
  end

  initial begin
    int sel, fs, ms;
    logic [5:0] op;
    @(posedge clk); #1;
    do_reset();
    // Directed cases
    issue(OP_R, 0, 0);
    issue(OP_LW, 0, 3);
    issue(OP_SW, 0, 0);
    issue(OP_BEQ, 0, 0);
    issue(OP_BAD, 0, 0);
    issue(OP_J, 0, 0);
    issue(OP_R, LIM, 0);
    issue(OP_R, LIM + 1, 0);
    issue(OP_LW, 0, LIM + 1);
    issue(OP_SW, 2, LIM);
    // Reset in the middle of a stalled store
    emit(rnd_op(), 1'b1, "fetch");
    emit(OP_SW, rnd_bit(), "decode");
    emit(rnd_op(), rnd_bit(), "mem_addr");
    emit(rnd_op(), 1'b0, "mem_write");
    do_reset();
    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = OP_R;
        2, 3:    op = OP_LW;
        4, 5:    op = OP_SW;
        6, 7:    op = OP_BEQ;
        8:       op = OP_J;
        default: op = rnd_op();
      endcase
      fs = ($urandom_range(0, 19) == 0) ? LIM + 1 : $urandom_range(0, 2);
      ms = ($urandom_range(0, 19) == 0) ? LIM + 1 : $urandom_range(0, LIM);
      issue(op, fs, ms);
    end
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
